async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter NDATABITS, default 32, data word width in bits.
REQ-002 SHALL have parameter NADDRBITS, default 4, log2 of FIFO depth (depth = 2^NADDRBITS = 16 words).
REQ-003 SHALL have port clk_i  input  1  single clock for write and read sides, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-005 SHALL have port dataW_i  input  NDATABITS  write data, sampled when validW_i and readyW_o are both high.
REQ-006 SHALL have port validW_i  input  1  source offers dataW_i this cycle.
REQ-007 SHALL have port readyW_o  output  1  FIFO can accept a word this cycle (not full).
REQ-008 SHALL have port dataR_o  output  NDATABITS  oldest stored word; meaningful only while validR_o is high.
REQ-009 SHALL have port validR_o  output  1  FIFO holds at least one word (not empty).
REQ-010 SHALL have port readyR_i  input  1  sink consumes dataR_o this cycle.

Function
REQ-011 SHALL perform a write on a rising clk_i edge when validW_i and readyW_o are both high, storing dataW_i at the write pointer and incrementing it.
REQ-012 SHALL perform a read on a rising clk_i edge when validR_o and readyR_i are both high, incrementing the read pointer.
REQ-013 SHALL ignore validW_i while readyW_o is low, and readyR_i while validR_o is low; no pointer or storage change results.
REQ-014 SHALL use NADDRBITS+1-bit binary pointers wrapping modulo 2^(NADDRBITS+1); the low NADDRBITS bits address storage.
REQ-015 SHALL define empty as pointers equal, and full as low bits equal with MSBs differing.
REQ-016 SHALL drive readyW_o = not full and validR_o = not empty, both derived only from registered pointers, never combinationally from validW_i or readyR_i.
REQ-017 SHALL present data first-word-fall-through: dataR_o equals the word at the read pointer whenever validR_o is high, with no read-request latency.
REQ-018 SHALL make a word written at edge N visible (validR_o high, dataR_o valid) from edge N onward, so write-to-read latency is one cycle.
REQ-019 SHALL, when full, keep readyW_o low even if a read occurs in the same cycle; readyW_o rises the cycle after the read.
REQ-020 SHALL, when empty, keep validR_o low even if a write occurs in the same cycle; no bypass path exists.
REQ-021 SHALL support a simultaneous read and write when neither full nor empty, leaving occupancy unchanged.
REQ-022 SHALL deliver words in exact write order with no loss or duplication across any pointer wrap-around.
REQ-023 SHALL drive dataR_o with unspecified content while validR_o is low.

Reset
REQ-024 SHALL, on a clk_i edge with rst_i high, clear both pointers to zero, discarding all stored words, including mid-operation.
REQ-025 SHALL hold validR_o=0 and readyW_o=1 from the first edge with rst_i high until the first accepted write.
REQ-026 SHALL ignore validW_i and readyR_i on any edge where rst_i is high.
REQ-027 SHALL NOT reset the storage array.

Structure
REQ-028 SHALL need no shared package; widths come from the two parameters only.
REQ-029 SHALL place storage in one sub-module fifo_mem: a simple dual-port array with a synchronous write port and an asynchronous read port, NDATABITS x 2^NADDRBITS.
REQ-030 SHALL keep pointer and flag logic in async_fifo. An output register stage, if needed downstream, is a separate block and not part of this one.

Verification
REQ-031 SHALL verify fill: after reset, validW_i=1, readyR_i=0, data 0..15 -> 16 writes accepted, readyW_o=0 after the 16th, further offered data rejected, validR_o=1 with dataR_o=0.
REQ-032 SHALL verify drain: from full, readyR_i=1, validW_i=0 -> dataR_o reads 0..15 on consecutive cycles, then validR_o=0 and readyW_o=1.
REQ-033 SHALL verify boundary cases: single write of 0xA5 into empty FIFO -> validR_o high exactly one cycle after the write edge. Read while full -> readyW_o high the next cycle, not the same cycle.
REQ-034 SHALL verify random streaming: pseudo-random validW_i and readyR_i (24-bit LFSR bits), incrementing 32-bit source counter, 10000 cycles -> sink sees 0,1,2,... with no mismatch; include sink-faster and source-faster mixes.
REQ-035 SHALL verify reset mid-operation: write 5 words, assert rst_i one cycle -> validR_o=0 and readyW_o=1 next cycle; a subsequent write of 0x77 reads back as the first word.
REQ-036 SHALL verify wrap-around: 40 continuous writes and reads at full throughput (both handshakes high) -> one word per cycle, in order, across pointer wrap.

Source files
------------

// File: rtl/fifo_mem.sv
// fifo_mem
// Storage array for async_fifo: a simple dual-port RAM with NDATABITS-wide
// words and 2^NADDRBITS entries. Writes are synchronous to clk_i. Reads are
// asynchronous, so the FIFO can present its oldest word combinationally
// (first-word-fall-through). The array is never reset.
//
// Ports:
//   clk_i    - write clock, rising edge
//   wrEn_i   - write enable
//   wrAddr_i - write address
//   wrData_i - write data
//   rdAddr_i - read address
//   rdData_o - word stored at rdAddr_i (combinational)
module fifo_mem #(
    parameter int NDATABITS = 32,
    parameter int NADDRBITS = 4
) (
    input  logic                 clk_i,
    input  logic                 wrEn_i,
    input  logic [NADDRBITS-1:0] wrAddr_i,
    input  logic [NDATABITS-1:0] wrData_i,
    input  logic [NADDRBITS-1:0] rdAddr_i,
    output logic [NDATABITS-1:0] rdData_o
);

    localparam int DEPTH = 1 << NADDRBITS;

    logic [NDATABITS-1:0] memArray [DEPTH];

    // Synchronous write port. There is no reset, which lets the array map
    // onto distributed RAM or a register file.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            memArray[wrAddr_i] <= wrData_i;
        end
    end

    // Asynchronous read port; this gives the FIFO zero-latency head data.
    assign rdData_o = memArray[rdAddr_i];

endmodule

// File: rtl/async_fifo.sv
// async_fifo
// Single-clock FIFO with valid/ready handshakes on both sides and
// first-word-fall-through output. Depth is 2^NADDRBITS words. The pointers
// are NADDRBITS+1 bits wide so that full and empty can be told apart. The
// flags come only from registered pointers, so the handshake outputs never
// depend combinationally on validW_i or readyR_i.
//
// Ports:
//   clk_i    - clock for both sides, rising edge
//   rst_i    - synchronous active-high reset; clears the pointers only
//   dataW_i  - write data
//   validW_i - source offers dataW_i
//   readyW_o - FIFO not full
//   dataR_o  - oldest stored word; meaningful only while validR_o is high
//   validR_o - FIFO not empty
//   readyR_i - sink consumes dataR_o
module async_fifo #(
    parameter int NDATABITS = 32,
    parameter int NADDRBITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NDATABITS-1:0] dataW_i,
    input  logic                 validW_i,
    output logic                 readyW_o,
    output logic [NDATABITS-1:0] dataR_o,
    output logic                 validR_o,
    input  logic                 readyR_i
);

    localparam logic [NADDRBITS:0] PTR_ONE = 1;

    logic [NADDRBITS:0] wrPtr;
    logic [NADDRBITS:0] rdPtr;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               doWrite;
    logic               doRead;

    // Empty: the pointers match exactly.
    // Full: the pointers address the same slot but are one lap apart.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[NADDRBITS-1:0] == rdPtr[NADDRBITS-1:0]) &&
                       (wrPtr[NADDRBITS] != rdPtr[NADDRBITS]);

    assign readyW_o = ~fifoFull;
    assign validR_o = ~fifoEmpty;

    // Handshakes are masked during reset, so nothing is stored or consumed
    // on a reset edge.
    assign doWrite = validW_i & readyW_o & ~rst_i;
    assign doRead  = validR_o & readyR_i & ~rst_i;

    // Pointer registers. A reset discards every stored word by making the
    // pointers equal again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doRead) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    fifo_mem #(
        .NDATABITS(NDATABITS),
        .NADDRBITS(NADDRBITS)
    ) uMem (
        .clk_i    (clk_i),
        .wrEn_i   (doWrite),
        .wrAddr_i (wrPtr[NADDRBITS-1:0]),
        .wrData_i (dataW_i),
        .rdAddr_i (rdPtr[NADDRBITS-1:0]),
        .rdData_o (dataR_o)
    );

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo
// Directed and pseudo-random checks for async_fifo. A reference model keeps
// its own occupancy count and a queue of expected words. Every cycle the
// model predicts the flags and the head word, then commits the handshakes
// it expects the FIFO to accept.
module tb_async_fifo;

    localparam int NDATABITS = 32;
    localparam int NADDRBITS = 4;
    localparam int DEPTH     = 1 << NADDRBITS;

    logic                 clk_i;
    logic                 rst_i;
    logic [NDATABITS-1:0] dataW_i;
    logic                 validW_i;
    logic                 readyW_o;
    logic [NDATABITS-1:0] dataR_o;
    logic                 validR_o;
    logic                 readyR_i;

    logic [NDATABITS-1:0] expQ[$];
    int                   modelCount;
    int                   vectors;
    int                   miscompares;
    logic [NDATABITS-1:0] srcCounter;
    logic [23:0]          lfsr;

    async_fifo #(
        .NDATABITS(NDATABITS),
        .NADDRBITS(NADDRBITS)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .dataW_i  (dataW_i),
        .validW_i (validW_i),
        .readyW_o (readyW_o),
        .dataR_o  (dataR_o),
        .validR_o (validR_o),
        .readyR_i (readyR_i)
    );

    // 10 ns clock period
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    // One clock cycle. The inputs are driven just after a falling edge and
    // the outputs are checked against the model before the rising edge.
    // The model then commits the transfers the FIFO should perform on that
    // edge.
    task automatic applyStimulus(input logic vw, input logic [NDATABITS-1:0] d,
                                 input logic rr);
        logic willWrite;
        logic willRead;
        validW_i = vw;
        dataW_i  = d;
        readyR_i = rr;
        #1;
        checkOutput("readyW", {31'b0, readyW_o}, {31'b0, modelCount < DEPTH});
        checkOutput("validR", {31'b0, validR_o}, {31'b0, modelCount > 0});
        if (modelCount > 0) begin
            checkOutput("dataR", dataR_o, expQ[0]);
        end
        willWrite = vw && (modelCount < DEPTH);
        willRead  = rr && (modelCount > 0);
        if (willRead) begin
            void'(expQ.pop_front());
            modelCount--;
        end
        if (willWrite) begin
            expQ.push_back(d);
            modelCount++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Hold rst_i for one edge while offering both handshakes; the FIFO must
    // ignore them.
    task automatic doReset();
        rst_i    = 1'b1;
        validW_i = 1'b1;
        readyR_i = 1'b1;
        dataW_i  = 32'hDEAD_BEEF;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i    = 1'b0;
        validW_i = 1'b0;
        readyR_i = 1'b0;
        expQ.delete();
        modelCount = 0;
    endtask

    // One stream of pseudo-random traffic. The LFSR drives both handshakes,
    // and the write threshold and read threshold set the mix.
    task automatic randomPhase(input int cycles, input int wThresh, input int rThresh);
        logic vw;
        logic rr;
        for (int i = 0; i < cycles; i++) begin
            lfsr = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
            vw = (int'(lfsr[3:0]) < wThresh);
            rr = (int'(lfsr[11:8]) < rThresh);
            if (vw && modelCount < DEPTH) begin
                applyStimulus(vw, srcCounter, rr);
                srcCounter = srcCounter + 32'd1;
            end else begin
                applyStimulus(vw, srcCounter, rr);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelCount  = 0;
        srcCounter  = '0;
        lfsr        = 24'hACE1_35;
        rst_i       = 1'b0;
        validW_i    = 1'b0;
        readyR_i    = 1'b0;
        dataW_i     = '0;
        @(negedge clk_i);

        // Reset state
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Fill: offer 17 words; the last one must be rejected
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Drain: 16 consecutive reads, then empty
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Single write into an empty FIFO; validR_o must rise one cycle later
        applyStimulus(1'b1, 32'h0000_00A5, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Read and write while full: the write is refused and readyW_o
        // rises only on the following cycle
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 32'h0000_0BAD, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end

        // Reset partway through operation
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h50 + 32'(i), 1'b0);
        end
        doReset();
        applyStimulus(1'b1, 32'h0000_0077, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Wrap-around at full throughput: prime one word, then keep both
        // handshakes high for 40 cycles
        applyStimulus(1'b1, 32'h1000, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Random streaming: the source and sink are balanced, then the source
        // is faster, then the sink is faster
        doReset();
        randomPhase(3334, 8, 8);
        randomPhase(3333, 13, 5);
        randomPhase(3333, 5, 13);
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
